// File: rtl/ysyx_23060111_lsu.sv
// rtl/ysyx_23060111_lsu.sv - one-deep load/store unit with registered bus handshake
// Accepts one EXU memory op, issues a masked word-aligned bus request, returns extended load data.
module ysyx_23060111_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_err
);
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  state_t r_state, w_next;

  logic        r_wen;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_mem_addr, r_mem_wdata, r_rdata;
  logic [3:0]  r_mem_wmask;
  logic        r_err;
  logic [7:0]  r_cnt;

  logic        w_bad, w_timeout;
  logic [31:0] w_wdata, w_load, w_shift;
  logic [3:0]  w_wmask;
  logic [15:0] w_half;

  // Illegal funct3 or a half/word access that is not naturally aligned.
  always_comb begin
    w_bad = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & (req_wen | req_funct3[1]));
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      w_bad = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      w_bad = 1'b1;
  end

  always_comb begin
    w_wdata = req_wdata;
    w_wmask = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        w_wdata = {4{req_wdata[7:0]}};
        w_wmask = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{req_wdata[15:0]}};
        w_wmask = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
    if (!req_wen)
      w_wmask = 4'b0000;
  end

  always_comb begin
    w_shift = mem_resp_rdata >> {r_off, 3'b000};
    w_half  = r_off[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_resp_rdata;
    endcase
  end

  assign w_timeout = (r_cnt == LP_TIMEOUT);

  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_bad ? S_RESP : S_REQ;
      S_REQ:   if (mem_req_ready) w_next = S_WAIT;
      S_WAIT:  if (mem_resp_valid || w_timeout) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (r_state == S_IDLE);
    mem_req_valid = (r_state == S_REQ);
    resp_valid    = (r_state == S_RESP);
    resp_rdata    = r_rdata;
    resp_err      = r_err;
    mem_wen       = r_wen;
    mem_addr      = r_mem_addr;
    mem_wdata     = r_mem_wdata;
    mem_wmask     = r_mem_wmask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wen       <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wmask <= 4'd0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_wen       <= req_wen;
          r_funct3    <= req_funct3;
          r_off       <= req_addr[1:0];
          r_mem_addr  <= {req_addr[31:2], 2'b00};
          r_mem_wdata <= w_wdata;
          r_mem_wmask <= w_wmask;
          r_rdata     <= 32'd0;
          r_err       <= w_bad;
        end
        S_REQ: if (mem_req_ready) r_cnt <= 8'd0;
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (mem_resp_valid) begin
            r_err   <= mem_resp_err;
            r_rdata <= (r_wen || mem_resp_err) ? 32'd0 : w_load;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end
        end
        default: begin
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
        end
      endcase
    end
  end
endmodule

// File: doc/ysyx_23060111_lsu.md
# ysyx_23060111_lsu

Load/store unit between the execute stage and data memory. It replaces the combinational memory port with a registered, multi-cycle handshake: it accepts one load or store from EXU, issues it as a word-aligned bus request with a byte mask, waits for a variable-latency response, and returns sign- or zero-extended load data. It is one transaction deep and stalls EXU through `req_ready`.

## Interface
Parameters:
- TIMEOUT, 255, maximum cycles in WAIT before the transaction is aborted with error; 1..255, 8-bit counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset (applied when rst==0 at a rising clk edge)
- req_valid  in  1  EXU presents a memory operation
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_wen  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle pulse: transaction complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, illegal funct3, bus error or timeout
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_wen  out  1  bus write
- mem_addr  out  32  req_addr with bits [1:0] forced to 0
- mem_wdata  out  32  store data shifted to byte lane
- mem_wmask  out  4  byte-enable; 0000 for loads
- mem_resp_valid  in  1  bus response
- mem_resp_rdata  in  32  bus read word
- mem_resp_err  in  1  bus error, qualified by mem_resp_valid

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch wen, funct3, addr[1:0], and compute mem_addr/mem_wdata/mem_wmask into registers.
  - Illegal funct3 (load 011/110/111; store ≥011) or misalignment (half with addr[0]=1, word with addr[1:0]≠00) -> RESP with err=1, no bus transaction.
  - Otherwise -> REQ.
- REQ: mem_req_valid=1, bus outputs held stable. When mem_req_ready, go to WAIT and clear the timeout counter.
- WAIT: the counter increments every cycle.
  - On mem_resp_valid -> RESP; latch err=mem_resp_err.
  - Else when the counter == TIMEOUT -> RESP with err=1.
  - A response arriving in the same cycle as the timeout wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The next request is accepted no earlier than the following cycle.
- Store lanes:
  - sb: wmask = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}
  - sh: wmask = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}
  - sw: wmask = 1111, wdata unchanged
- Load extract: byte = rdata[8*addr[1:0] +: 8], half = rdata[16*addr[1] +: 16]. lb/lh sign-extend, lbu/lhu zero-extend, lw passes through. Latched into resp_rdata on response.
- mem_resp_valid is ignored outside WAIT. mem_req_ready is ignored outside REQ.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_req_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0, counter=0.
- Reset mid-transaction (any state) returns to IDLE next edge. An outstanding bus response arriving later is dropped because WAIT is not active.
- All outputs are registered. No combinational path from any input to any output.
- Minimum latency: accept at cycle 0, mem_req_valid at cycle 1, ready at 1, response at 2, resp_valid at 3.
- Error short path: accept at cycle 0, resp_valid+resp_err at cycle 1.
- Timeout: resp_valid occurs TIMEOUT+1 cycles after the cycle where the counter was cleared (entering WAIT).
- Back-to-back throughput: one transaction per ≥4 cycles.

## Test plan
- lw addr 0x80000010, bus ready immediately, rdata 0xDEADBEEF at next cycle -> resp_valid at cycle 3, resp_rdata 0xDEADBEEF, err 0, mem_addr 0x80000010, wmask 0000.
- lb addr 0x80000013, rdata 0x80FF7F01 -> resp_rdata 0xFFFFFF80. Same access with lbu -> 0x00000080.
- sh addr 0x80000002, wdata 0x1234ABCD -> mem_wmask 1100, mem_wdata 0xABCDABCD, mem_wen 1, resp_rdata 0.
- lw addr 0x80000001 -> resp_valid+resp_err at cycle 1, mem_req_valid never asserted. funct3 011 load -> same response.
- mem_req_ready held low 5 cycles -> request stays stable. Then no response with TIMEOUT=4 -> resp_err=1 exactly 5 cycles after entering WAIT.
- rst driven 0 during WAIT -> all outputs at reset values next cycle. A late mem_resp_valid is ignored. A new lw then completes normally.
